// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : morse_pkg
// Brief    : State encoding, Morse unit lengths, char-code constants, ROM helper
// Revision : 1.0
// ============================================================================
package morse_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MARK = 3'd1;
  localparam logic [2:0] S_EGAP = 3'd2;
  localparam logic [2:0] S_LGAP = 3'd3;
  localparam logic [2:0] S_WGAP = 3'd4;

  localparam int DOT_U        = 1;
  localparam int DASH_U       = 3;
  localparam int EGAP_U       = 1;
  localparam int LGAP_U       = 3;
  localparam int WGAP_EXTRA_U = 4;

  localparam logic [5:0] CODE_A   = 6'd0;
  localparam logic [5:0] CODE_0   = 6'd26;
  localparam logic [5:0] CODE_MAX = 6'd35;

  // Patterns are written right-aligned and stored left-aligned so bit 4 is always the next element.
  function automatic logic [7:0] mk_entry(input logic [2:0] len, input logic [4:0] bits);
    logic [4:0] aligned;
    aligned = bits << (3'd5 - len);
    return {len, aligned};
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_rom.sv
`default_nettype none
// ============================================================================
// Module   : morse_rom
// Brief    : Combinational char_code -> {len, pat}; len=0 marks an invalid code
// Revision : 1.0
// ============================================================================
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] char_code,
  output logic [2:0] len,
  output logic [4:0] pat
);

  logic [7:0] w_entry;

  always_comb begin
    w_entry = 8'd0;
    case (char_code)
      CODE_A + 6'd0:  w_entry = mk_entry(3'd2, 5'b00001); // A .-
      CODE_A + 6'd1:  w_entry = mk_entry(3'd4, 5'b01000); // B -...
      CODE_A + 6'd2:  w_entry = mk_entry(3'd4, 5'b01010); // C -.-.
      CODE_A + 6'd3:  w_entry = mk_entry(3'd3, 5'b00100); // D -..
      CODE_A + 6'd4:  w_entry = mk_entry(3'd1, 5'b00000); // E .
      CODE_A + 6'd5:  w_entry = mk_entry(3'd4, 5'b00010); // F ..-.
      CODE_A + 6'd6:  w_entry = mk_entry(3'd3, 5'b00110); // G --.
      CODE_A + 6'd7:  w_entry = mk_entry(3'd4, 5'b00000); // H ....
      CODE_A + 6'd8:  w_entry = mk_entry(3'd2, 5'b00000); // I ..
      CODE_A + 6'd9:  w_entry = mk_entry(3'd4, 5'b00111); // J .---
      CODE_A + 6'd10: w_entry = mk_entry(3'd3, 5'b00101); // K -.-
      CODE_A + 6'd11: w_entry = mk_entry(3'd4, 5'b00100); // L .-..
      CODE_A + 6'd12: w_entry = mk_entry(3'd2, 5'b00011); // M --
      CODE_A + 6'd13: w_entry = mk_entry(3'd2, 5'b00010); // N -.
      CODE_A + 6'd14: w_entry = mk_entry(3'd3, 5'b00111); // O ---
      CODE_A + 6'd15: w_entry = mk_entry(3'd4, 5'b00110); // P .--.
      CODE_A + 6'd16: w_entry = mk_entry(3'd4, 5'b01101); // Q --.-
      CODE_A + 6'd17: w_entry = mk_entry(3'd3, 5'b00010); // R .-.
      CODE_A + 6'd18: w_entry = mk_entry(3'd3, 5'b00000); // S ...
      CODE_A + 6'd19: w_entry = mk_entry(3'd1, 5'b00001); // T -
      CODE_A + 6'd20: w_entry = mk_entry(3'd3, 5'b00001); // U ..-
      CODE_A + 6'd21: w_entry = mk_entry(3'd4, 5'b00001); // V ...-
      CODE_A + 6'd22: w_entry = mk_entry(3'd3, 5'b00011); // W .--
      CODE_A + 6'd23: w_entry = mk_entry(3'd4, 5'b01001); // X -..-
      CODE_A + 6'd24: w_entry = mk_entry(3'd4, 5'b01011); // Y -.--
      CODE_A + 6'd25: w_entry = mk_entry(3'd4, 5'b01100); // Z --..
      CODE_0 + 6'd0:  w_entry = mk_entry(3'd5, 5'b11111);
      CODE_0 + 6'd1:  w_entry = mk_entry(3'd5, 5'b01111);
      CODE_0 + 6'd2:  w_entry = mk_entry(3'd5, 5'b00111);
      CODE_0 + 6'd3:  w_entry = mk_entry(3'd5, 5'b00011);
      CODE_0 + 6'd4:  w_entry = mk_entry(3'd5, 5'b00001);
      CODE_0 + 6'd5:  w_entry = mk_entry(3'd5, 5'b00000);
      CODE_0 + 6'd6:  w_entry = mk_entry(3'd5, 5'b10000);
      CODE_0 + 6'd7:  w_entry = mk_entry(3'd5, 5'b11000);
      CODE_0 + 6'd8:  w_entry = mk_entry(3'd5, 5'b11100);
      CODE_MAX:       w_entry = mk_entry(3'd5, 5'b11110);
      default:        w_entry = 8'd0;
    endcase
  end

  assign len = w_entry[7:5];
  assign pat = w_entry[4:0];

endmodule
`default_nettype wire

// File: rtl/morse_keyer.sv
`default_nettype none
// ============================================================================
// Module   : morse_keyer
// Brief    : Single-character Morse transmitter with ITU timing, handshake, abort, repeat
// Revision : 1.0
// ============================================================================
module morse_keyer
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES = 25_000_000,
  parameter int CNT_W       = 25
)
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] char_code,
  input  logic       repeat_en,
  input  logic       abort,
  output logic       ready,
  output logic       busy,
  output logic       key_out,
  output logic       done,
  output logic       err
);

  localparam logic [CNT_W-1:0] c_reload = CNT_W'(UNIT_CYCLES - 1);

  logic [2:0]       w_rom_len;
  logic [4:0]       w_rom_pat;
  logic [2:0]       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_units, w_units_load;
  logic [2:0]       r_elems, r_len;
  logic [4:0]       r_shift, r_pat;
  logic             r_key, r_done, r_err;
  logic             w_key_nxt, w_done_nxt, w_err_nxt;
  logic             w_tick, w_last, w_accept, w_invalid, w_enter, w_mark_bit;

  morse_rom u_rom (
    .char_code (char_code),
    .len       (w_rom_len),
    .pat       (w_rom_pat)
  );

  assign w_tick    = (r_cnt == '0);
  assign w_last    = w_tick && (r_units == 2'd0);
  assign w_accept  = start && (r_state == S_IDLE) && !abort;
  assign w_invalid = (w_rom_len == 3'd0);
  assign w_enter   = (w_state_nxt != r_state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept && !w_invalid) w_state_nxt = S_MARK;
        S_MARK: if (w_last) w_state_nxt = (r_elems == 3'd1) ? S_LGAP : S_EGAP;
        S_EGAP: if (w_last) w_state_nxt = S_MARK;
        S_LGAP: if (w_last) w_state_nxt = repeat_en ? S_WGAP : S_IDLE;
        S_WGAP: if (w_last) w_state_nxt = S_MARK;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The element about to be keyed comes from the ROM on a fresh start, the latched copy on a repeat.
  always_comb begin
    w_mark_bit = r_shift[4];
    if (r_state == S_IDLE)      w_mark_bit = w_rom_pat[4];
    else if (r_state == S_WGAP) w_mark_bit = r_pat[4];
    case (w_state_nxt)
      S_MARK:  w_units_load = w_mark_bit ? 2'(DASH_U - 1) : 2'(DOT_U - 1);
      S_EGAP:  w_units_load = 2'(EGAP_U - 1);
      S_LGAP:  w_units_load = 2'(LGAP_U - 1);
      S_WGAP:  w_units_load = 2'(WGAP_EXTRA_U - 1);
      default: w_units_load = 2'd0;
    endcase
    w_key_nxt  = (w_state_nxt == S_MARK);
    w_err_nxt  = w_accept && w_invalid;
    w_done_nxt = w_err_nxt || (r_state == S_LGAP && w_state_nxt == S_IDLE && !abort);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_units <= 2'd0;
      r_elems <= 3'd0;
      r_shift <= 5'd0;
      r_len   <= 3'd0;
      r_pat   <= 5'd0;
      r_key   <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_key  <= w_key_nxt;
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (w_accept) begin
        r_len <= w_rom_len;
        r_pat <= w_rom_pat;
      end
      if (w_state_nxt == S_IDLE)  r_cnt <= '0;
      else if (w_enter || w_tick) r_cnt <= c_reload;
      else                        r_cnt <= r_cnt - CNT_W'(1);
      if (w_enter)                           r_units <= w_units_load;
      else if (w_tick && r_state != S_IDLE)  r_units <= r_units - 2'd1;
      if (w_accept) begin
        r_shift <= w_rom_pat;
        r_elems <= w_rom_len;
      end else if (r_state == S_WGAP && w_state_nxt == S_MARK) begin
        r_shift <= r_pat;
        r_elems <= r_len;
      end else if (r_state == S_MARK && w_enter) begin
        r_shift <= r_shift << 1;
        r_elems <= r_elems - 3'd1;
      end
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign busy    = ~ready;
  assign key_out = r_key;
  assign done    = r_done;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_morse_keyer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_morse_keyer
// Brief    : Scoreboard bench for morse_keyer with UNIT_CYCLES=4
// Revision : 1.0
// ============================================================================
module tb_morse_keyer;

  localparam int UNIT = 4;
  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_DONE = 2;
  localparam int EV_ERR  = 3;

  typedef struct {
    int   kind;
    int   cyc;
    logic err;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] char_code = 6'd0;
  logic       repeat_en = 1'b0;
  logic       abort = 1'b0;
  logic       ready, busy, key_out, done, err;

  ev_t  exp_q[$];
  int   cyc = 0;
  int   t0 = 0;
  int   tests = 0;
  int   fails = 0;
  logic prev_key = 1'b0;

  morse_keyer #(.UNIT_CYCLES(UNIT), .CNT_W(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .char_code (char_code),
    .repeat_en (repeat_en),
    .abort     (abort),
    .ready     (ready),
    .busy      (busy),
    .key_out   (key_out),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic exp_ev(input int kind, input int rel, input logic e);
    ev_t x;
    x.kind = kind;
    x.cyc  = t0 + rel;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  task automatic observe(input int kind, input logic e);
    ev_t x;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected no event", kind, cyc);
    end else begin
      x = exp_q.pop_front();
      check("event_kind", kind, x.kind);
      check("event_cycle", cyc, x.cyc);
      if (kind == EV_DONE) check("event_err", {31'd0, e}, {31'd0, x.err});
    end
  endtask

  // Monitor: every key edge and every done/err pulse is an output event matched against the queue.
  always @(negedge clk) begin
    if (key_out !== prev_key) observe(key_out ? EV_RISE : EV_FALL, 1'b0);
    prev_key = key_out;
    if (done === 1'b1)     observe(EV_DONE, err);
    else if (err !== 1'b0) observe(EV_ERR, err);
  end

  task automatic send(input logic [5:0] code, input logic rep);
    char_code = code;
    repeat_en = rep;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_done: got no done within %0d cycles, expected a done pulse", limit);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_busy"},  {31'd0, busy},  32'd0);
    check({tag, "_key"},   {31'd0, key_out}, 32'd0);
    check({tag, "_done"},  {31'd0, done},  32'd0);
    check({tag, "_err"},   {31'd0, err},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // 'E'
    t0 = cyc;
    exp_ev(EV_RISE, 1, 1'b0); exp_ev(EV_FALL, 5, 1'b0); exp_ev(EV_DONE, 17, 1'b0);
    send(6'd4, 1'b0);
    wait_done(200);

    // 'T' started in the done cycle of 'E'
    t0 = cyc;
    exp_ev(EV_RISE, 1, 1'b0); exp_ev(EV_FALL, 13, 1'b0); exp_ev(EV_DONE, 25, 1'b0);
    send(6'd19, 1'b0);
    wait_done(200);
    check("ready_with_done", {31'd0, ready}, 32'd1);
    @(negedge clk);

    // '0': five dashes
    t0 = cyc;
    for (int k = 0; k < 5; k++) begin
      exp_ev(EV_RISE, 1 + 16 * k, 1'b0);
      exp_ev(EV_FALL, 13 + 16 * k, 1'b0);
    end
    exp_ev(EV_DONE, 89, 1'b0);
    send(6'd26, 1'b0);
    wait_done(300);
    @(negedge clk);

    // invalid code 40
    t0 = cyc;
    exp_ev(EV_DONE, 1, 1'b1);
    send(6'd40, 1'b0);
    wait_done(10);
    check("ready_after_invalid", {31'd0, ready}, 32'd1);
    @(negedge clk);

    // 'Y' -.-- with an ignored start at cycle 5
    t0 = cyc;
    exp_ev(EV_RISE, 1, 1'b0);  exp_ev(EV_FALL, 13, 1'b0);
    exp_ev(EV_RISE, 17, 1'b0); exp_ev(EV_FALL, 21, 1'b0);
    exp_ev(EV_RISE, 25, 1'b0); exp_ev(EV_FALL, 37, 1'b0);
    exp_ev(EV_RISE, 41, 1'b0); exp_ev(EV_FALL, 53, 1'b0);
    exp_ev(EV_DONE, 65, 1'b0);
    send(6'd24, 1'b0);
    repeat (4) @(negedge clk);
    char_code = 6'd4;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    check("busy_during_y", {31'd0, busy}, 32'd1);
    wait_done(200);
    @(negedge clk);

    // abort and start together in IDLE: start ignored
    char_code = 6'd4;
    start     = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    abort     = 1'b0;
    check("abort_start_ready", {31'd0, ready}, 32'd1);
    @(negedge clk);

    // 'E' with repeat, aborted at cycle 35
    t0 = cyc;
    exp_ev(EV_RISE, 1, 1'b0);  exp_ev(EV_FALL, 5, 1'b0);
    exp_ev(EV_RISE, 33, 1'b0); exp_ev(EV_FALL, 36, 1'b0);
    send(6'd4, 1'b1);
    repeat (34) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort     = 1'b0;
    repeat_en = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_key",   {31'd0, key_out}, 32'd0);
    repeat (60) @(negedge clk);

    // 'S' interrupted by reset at cycle 6, then sent again
    t0 = cyc;
    exp_ev(EV_RISE, 1, 1'b0); exp_ev(EV_FALL, 5, 1'b0);
    send(6'd18, 1'b0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    t0 = cyc;
    exp_ev(EV_RISE, 1, 1'b0);  exp_ev(EV_FALL, 5, 1'b0);
    exp_ev(EV_RISE, 9, 1'b0);  exp_ev(EV_FALL, 13, 1'b0);
    exp_ev(EV_RISE, 17, 1'b0); exp_ev(EV_FALL, 21, 1'b0);
    exp_ev(EV_DONE, 33, 1'b0);
    send(6'd18, 1'b0);
    wait_done(200);
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
